alu_issue_stage: RTL

//  Upstream issue stage for the 32-bit ALU. Decodes ALUOp/funct3/funct7 into the ALU's 4-bit operation code.

---
 rtl/alu_issue_stage_if.sv | 31 +++
 rtl/alu_issue_stage.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage_if.sv
// Handshake and operand bundle between the issue driver and alu_issue_stage.
// The master side feeds requests and accepts issued ops; the slave side is the stage itself.
interface alu_issue_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_alu_op;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_operation;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic              out_illegal;
  logic [CNT_W-1:0]  illegal_cnt;

  modport master (
    output in_valid, in_alu_op, in_funct3, in_funct7, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_operation, out_a, out_b, out_illegal, illegal_cnt
  );

  modport slave (
    input  in_valid, in_alu_op, in_funct3, in_funct7, in_a, in_b, out_ready,
    output in_ready, out_valid, out_operation, out_a, out_b, out_illegal, illegal_cnt
  );
endinterface

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes ALUOp/funct3/funct7 and issues through a 2-entry skid buffer.
// Optional ALU_ISSUE_SHAMT_MASK_EN: clears B[DATA_W-1:5] for SLL/SRL/SRA.
module alu_issue_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input logic               clk,
  input logic               rst_n,
  alu_issue_stage_if.slave  bus_io
);

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpOr  = 4'b0001;
  localparam logic [3:0] OpAdd = 4'b0010;
  localparam logic [3:0] OpXor = 4'b0011;
  localparam logic [3:0] OpSll = 4'b0100;
  localparam logic [3:0] OpSub = 4'b0110;
  localparam logic [3:0] OpMul = 4'b0111;
  localparam logic [3:0] OpEq  = 4'b1000;
  localparam logic [3:0] OpNe  = 4'b1001;
  localparam logic [3:0] OpLt  = 4'b1010;
  localparam logic [3:0] OpGe  = 4'b1011;
  localparam logic [3:0] OpSrl = 4'b1100;
  localparam logic [3:0] OpIll = 4'b1101;
  localparam logic [3:0] OpSra = 4'b1110;
  localparam logic [3:0] OpDiv = 4'b1111;

  typedef struct packed {
    logic              ill;
    logic [3:0]        op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } entry_t;

  logic [3:0]       dec_op;
  logic [DATA_W-1:0] dec_b;
  entry_t           in_entry;
  entry_t           out_q, out_d, skid_q, skid_d;
  logic             out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, out_free;

  always_comb begin
    dec_op = OpIll;
    unique case (bus_io.in_alu_op)
      2'b00: dec_op = OpAdd;
      2'b01: begin
        case (bus_io.in_funct3)
          3'b000:  dec_op = OpEq;
          3'b001:  dec_op = OpNe;
          3'b100:  dec_op = OpLt;
          3'b101:  dec_op = OpGe;
          default: dec_op = OpIll;
        endcase
      end
      2'b10: begin
        if (bus_io.in_funct7 == 7'b0000000) begin
          case (bus_io.in_funct3)
            3'b000:  dec_op = OpAdd;
            3'b001:  dec_op = OpSll;
            3'b100:  dec_op = OpXor;
            3'b101:  dec_op = OpSrl;
            3'b110:  dec_op = OpOr;
            3'b111:  dec_op = OpAnd;
            default: dec_op = OpIll;
          endcase
        end else if (bus_io.in_funct7 == 7'b0100000) begin
          case (bus_io.in_funct3)
            3'b000:  dec_op = OpSub;
            3'b101:  dec_op = OpSra;
            default: dec_op = OpIll;
          endcase
        end else if (bus_io.in_funct7 == 7'b0000001) begin
          case (bus_io.in_funct3)
            3'b000:  dec_op = OpMul;
            3'b100:  dec_op = OpDiv;
            default: dec_op = OpIll;
          endcase
        end
      end
      2'b11: begin
        case (bus_io.in_funct3)
          3'b000:  dec_op = OpAdd;
          3'b100:  dec_op = OpXor;
          3'b110:  dec_op = OpOr;
          3'b111:  dec_op = OpAnd;
          3'b001:  dec_op = (bus_io.in_funct7 == 7'b0000000) ? OpSll : OpIll;
          3'b101: begin
            if (bus_io.in_funct7 == 7'b0000000)      dec_op = OpSrl;
            else if (bus_io.in_funct7 == 7'b0100000) dec_op = OpSra;
            else                                     dec_op = OpIll;
          end
          default: dec_op = OpIll;
        endcase
      end
      default: dec_op = OpIll;
    endcase

    dec_b = bus_io.in_b;
`ifdef ALU_ISSUE_SHAMT_MASK_EN
    if (dec_op == OpSll || dec_op == OpSrl || dec_op == OpSra) dec_b[DATA_W-1:5] = '0;
`endif
    in_entry = '{ill: (dec_op == OpIll), op: dec_op, a: bus_io.in_a, b: dec_b};
  end

  // in_ready depends only on skid occupancy, so out_ready never reaches it combinationally.
  assign accept   = bus_io.in_valid && !skid_valid_q;
  assign out_free = !out_valid_q || bus_io.out_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (out_free) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = in_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = in_entry;
      skid_valid_d = 1'b1;
    end

    cnt_d = cnt_q;
    if (accept && in_entry.ill && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus_io.in_ready      = !skid_valid_q;
  assign bus_io.out_valid     = out_valid_q;
  assign bus_io.out_operation = out_q.op;
  assign bus_io.out_a         = out_q.a;
  assign bus_io.out_b         = out_q.b;
  assign bus_io.out_illegal   = out_q.ill;
  assign bus_io.illegal_cnt   = cnt_q;

endmodule
